// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl
// Multiplexed four-digit seven-segment scan controller. Each digit owns a slot
// of SLOT_CYCLES clocks: the digit is driven for the first
// SLOT_CYCLES-GAP_CYCLES clocks, and the last GAP_CYCLES clocks are dead time
// so the segment lines can settle before the next digit is driven.
// New values are captured into a pending register while scanning. They move
// into the display register only at a frame boundary or when scanning stops,
// so a frame is never shown half old and half new.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_enable     scanning enabled when high
//   i_data       four hex digits, digit k = i_data[4k+3:4k]
//   i_load       single-cycle strobe capturing i_data
//   i_blank_lz   leading-zero blanking enable
//   o_nibble     digit value for the shared hex-to-seven-segment decoder
//   o_digit_en   one-hot digit enable, active-high
//   o_pending    a loaded value is waiting for the frame boundary
//   o_frame_done one-cycle pulse after the last cycle of a frame
// ---------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int SLOT_CYCLES = 1000,
    parameter int GAP_CYCLES  = 50
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [15:0] i_data,
    input  logic        i_load,
    input  logic        i_blank_lz,
    output logic [3:0]  o_nibble,
    output logic [3:0]  o_digit_en,
    output logic        o_pending,
    output logic        o_frame_done
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    // First count value that belongs to the dead-time part of the slot.
    localparam logic [CW-1:0] GAP_START = CW'(SLOT_CYCLES - GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]     r_idx, w_idx_nxt;
    logic [15:0]    r_disp, w_disp_nxt;
    logic [15:0]    r_pend, w_pend_nxt;
    logic           r_pending, w_pending_nxt;
    logic [3:0]     r_nibble, w_nibble_nxt;
    logic [3:0]     r_digit_en, w_digit_en_nxt;
    logic           r_frame_done;

    logic           w_scan;
    logic           w_last;
    logic           w_boundary;
    logic           w_leave;
    logic [3:0]     w_sel_nib;
    logic           w_upper_zero;

    assign w_scan     = (r_state != S_IDLE);
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_boundary = w_scan && w_last && (r_idx == 2'd3);
    assign w_leave    = w_scan && !i_enable;
    assign w_cnt_inc  = r_cnt + 1'b1;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pending    <= 1'b0;
            r_nibble     <= '0;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_disp       <= w_disp_nxt;
            r_pend       <= w_pend_nxt;
            r_pending    <= w_pending_nxt;
            r_nibble     <= w_nibble_nxt;
            r_digit_en   <= w_digit_en_nxt;
            r_frame_done <= w_boundary;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (i_enable) w_state_nxt = S_ON;
            end
            default: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (w_last) begin
                    w_state_nxt = S_ON;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = (w_cnt_inc < GAP_START) ? S_ON : S_GAP;
                end
            end
        endcase
    end

    // Display / pending datapath. A load that coincides with the boundary (or
    // with leaving the scan) wins over the older pending value.
    always_comb begin
        w_disp_nxt    = r_disp;
        w_pend_nxt    = r_pend;
        w_pending_nxt = r_pending;
        if (!w_scan) begin
            if (i_load) w_disp_nxt = i_data;
        end else if (w_boundary || w_leave) begin
            if (i_load)         w_disp_nxt = i_data;
            else if (r_pending) w_disp_nxt = r_pend;
            w_pending_nxt = 1'b0;
        end else if (i_load) begin
            w_pend_nxt    = i_data;
            w_pending_nxt = 1'b1;
        end
    end

    // ---------------- output logic ----------------
    // Outputs are computed from the next-cycle state and registered, so they
    // line up with the state they describe and no input reaches a port
    // without passing through a flop.
    always_comb begin
        w_sel_nib    = w_disp_nxt[3:0];
        w_upper_zero = 1'b0;
        case (w_idx_nxt)
            2'd0: begin
                w_sel_nib    = w_disp_nxt[3:0];
                w_upper_zero = 1'b0;
            end
            2'd1: begin
                w_sel_nib    = w_disp_nxt[7:4];
                w_upper_zero = (w_disp_nxt[15:4] == 12'd0);
            end
            2'd2: begin
                w_sel_nib    = w_disp_nxt[11:8];
                w_upper_zero = (w_disp_nxt[15:8] == 8'd0);
            end
            default: begin
                w_sel_nib    = w_disp_nxt[15:12];
                w_upper_zero = (w_disp_nxt[15:12] == 4'd0);
            end
        endcase

        w_nibble_nxt   = r_nibble;
        w_digit_en_nxt = 4'b0000;
        if (w_state_nxt == S_ON) begin
            w_nibble_nxt = w_sel_nib;
            if (!(i_blank_lz && w_upper_zero))
                w_digit_en_nxt = 4'b0001 << w_idx_nxt;
        end
    end

    assign o_nibble     = r_nibble;
    assign o_digit_en   = r_digit_en;
    assign o_pending    = r_pending;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;
    localparam int SLOT   = 8;
    localparam int GAP    = 2;
    localparam int ON_CYC = SLOT - GAP;
    localparam int FRAME  = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic        blank;
    logic [15:0] data;
    logic [3:0]  o_nibble;
    logic [3:0]  o_digit_en;
    logic        o_pending;
    logic        o_frame_done;

    sseg_scan_ctrl #(.SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_data       (data),
        .i_load       (load),
        .i_blank_lz   (blank),
        .o_nibble     (o_nibble),
        .o_digit_en   (o_digit_en),
        .o_pending    (o_pending),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time since the scan started, split into slot/digit
    // with plain division, plus the display / pending values.
    bit          m_scan;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    bit          m_pending;
    logic [3:0]  m_nib, m_en;
    bit          m_fd;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pending = 0;
        m_nib = '0; m_en = '0; m_fd = 0;
    endtask

    // Applies the inputs sampled at the edge just taken.
    task automatic model_step();
        int cnt, idx;
        logic [15:0] upper;
        m_fd = 0;
        if (!m_scan) begin
            if (load) m_disp = data;
            if (en) begin m_scan = 1; m_t = 0; end
        end else begin
            m_fd = ((m_t % FRAME) == FRAME - 1);
            if (m_fd || !en) begin
                if (load)           m_disp = data;
                else if (m_pending) m_disp = m_pend;
                m_pending = 0;
            end else if (load) begin
                m_pend = data; m_pending = 1;
            end
            if (!en) m_scan = 0;
            else     m_t++;
        end
        m_en = '0;
        if (m_scan) begin
            cnt = m_t % SLOT;
            idx = (m_t / SLOT) % 4;
            if (cnt < ON_CYC) begin
                upper = m_disp >> (4 * idx);
                m_nib = upper[3:0];
                if (!(idx > 0 && blank && upper == 16'd0)) m_en = 4'(1 << idx);
            end
        end
    endtask

    task automatic check_outs();
        chk("digit_en",   {12'd0, o_digit_en}, {12'd0, m_en});
        chk("nibble",     {12'd0, o_nibble},   {12'd0, m_nib});
        chk("pending",    {15'd0, o_pending},  {15'd0, m_pending});
        chk("frame_done", {15'd0, o_frame_done}, {15'd0, m_fd});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outs();
    endtask

    // Steps until the model is in slot idx at count cnt (inputs applied after
    // this returns are sampled in that cycle).
    task automatic run_to(input int idx, input int cnt);
        int guard;
        guard = 0;
        while (!(m_scan && (m_t % SLOT) == cnt && ((m_t / SLOT) % 4) == idx)) begin
            step();
            guard++;
            if (guard > 4 * FRAME) begin
                n_tests++; n_fail++;
                $display("FAIL run_to timeout idx=%0d cnt=%0d", idx, cnt);
                return;
            end
        end
    endtask

    task automatic load_one(input logic [15:0] v);
        load = 1'b1; data = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] en_or;
        int fd_cnt;
        rst = 1'b1; en = 1'b0; load = 1'b0; blank = 1'b0; data = '0;
        model_reset();
        #12;
        check_outs();
        @(negedge clk);
        rst = 1'b0;

        // Basic scan: load in IDLE, then enable.
        load_one(16'h1234);
        chk("idle_load_no_pending", {15'd0, o_pending}, 16'd0);
        en = 1'b1;
        step();
        chk("basic_first_en",  {12'd0, o_digit_en}, 16'h0001);
        chk("basic_first_nib", {12'd0, o_nibble},   16'h0004);
        fd_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            fd_cnt += int'(o_frame_done);
        end
        chk("frame_done_count", 16'(fd_cnt), 16'd2);

        // Leading-zero blanking.
        blank = 1'b1;
        load_one(16'h0050);
        run_to(3, SLOT - 1); step();
        en_or = '0;
        for (int i = 0; i < FRAME; i++) begin step(); en_or |= o_digit_en; end
        chk("blank_0050_en_or", {12'd0, en_or}, 16'h0003);
        load_one(16'h0000);
        run_to(3, SLOT - 1); step();
        en_or = '0;
        for (int i = 0; i < FRAME; i++) begin step(); en_or |= o_digit_en; end
        chk("blank_0000_en_or", {12'd0, en_or}, 16'h0001);
        blank = 1'b0;

        // Deferred load.
        load_one(16'h1234);
        run_to(3, SLOT - 1); step();
        run_to(1, 2);
        load_one(16'hABCD);
        chk("deferred_pending", {15'd0, o_pending}, 16'd1);
        run_to(3, SLOT - 1); step();
        chk("deferred_cleared", {15'd0, o_pending}, 16'd0);
        chk("deferred_new_nib", {12'd0, o_nibble},  16'h000D);
        for (int i = 0; i < FRAME; i++) step();

        // Boundary collision.
        run_to(1, 0);
        load_one(16'h1111);
        run_to(3, SLOT - 1);
        load_one(16'h2222);
        chk("collision_pending", {15'd0, o_pending}, 16'd0);
        chk("collision_nib",     {12'd0, o_nibble},  16'h0002);
        for (int i = 0; i < FRAME; i++) step();

        // Disable and re-enable.
        run_to(2, 3);
        en = 1'b0;
        step();
        chk("disable_en", {12'd0, o_digit_en}, 16'h0000);
        step(); step();
        en = 1'b1;
        step();
        chk("reenable_en", {12'd0, o_digit_en}, 16'h0001);
        for (int i = 0; i < SLOT; i++) step();

        // Asynchronous reset mid-ON with a pending value.
        run_to(0, 2);
        load_one(16'h5555);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outs();
        #1;
        rst = 1'b0;
        for (int i = 0; i < FRAME; i++) step();

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 39) != 0);
            load  = ($urandom_range(0, 9) == 0);
            data  = 16'($urandom);
            if ($urandom_range(0, 99) == 0) blank = ~blank;
            if ($urandom_range(0, 399) == 0) begin
                #2; rst = 1'b1; #1;
                model_reset();
                check_outs();
                #1; rst = 1'b0;
            end
            step();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
